// File: rtl/task_dispatch_pkg.sv
// rtl/task_dispatch_pkg.sv - header field positions, frame size, FSM states and end-of-program code
package task_dispatch_pkg;

    localparam int N_LSB       = 0;
    localparam int N_W         = 6;
    localparam int BARRIER_BIT = 6;
    localparam int EXCL_BIT    = 7;
    localparam int FRAME_WORDS = 16;

    localparam logic [15:0] END_OF_PROG = 16'h0000;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_HDR,
        ST_RD_M0,
        ST_RD_M1,
        ST_CHECK,
        ST_WAIT,
        ST_ISSUE,
        ST_DONE,
        ST_ERR
    } state_e;

    // Bits above the flag byte are reserved and must be zero.
    function automatic logic hdr_illegal(input logic [15:0] hdr);
        return hdr[15:8] != 8'h00;
    endfunction

endpackage

// File: rtl/core_resv_tracker.sv
// rtl/core_resv_tracker.sv - per-core reservation set/clear with rising-edge release on core_ready
module core_resv_tracker #(
    parameter int CORE_NUM = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CORE_NUM-1:0] core_ready,
    input  logic                set_en,
    input  logic [CORE_NUM-1:0] set_mask,
    output logic [CORE_NUM-1:0] reserved_mask,
    output logic [CORE_NUM-1:0] free_mask
);

    logic [CORE_NUM-1:0] ready_q;
    logic [CORE_NUM-1:0] resv_q;
    logic [CORE_NUM-1:0] resv_d;
    logic [CORE_NUM-1:0] rise;

    assign rise = core_ready & ~ready_q;

    // A grant landing on the same bit as a release keeps the core reserved.
    always_comb begin
        resv_d = resv_q & ~rise;
        if (set_en) begin
            resv_d = resv_d | set_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ready_q <= '0;
            resv_q  <= '0;
        end else begin
            ready_q <= core_ready;
            resv_q  <= resv_d;
        end
    end

    assign reserved_mask = resv_q;
    assign free_mask     = core_ready & ~resv_q;

endmodule

// File: rtl/task_dispatch_ctrl.sv
// rtl/task_dispatch_ctrl.sv - task program walker and dispatcher; MASK_CHECK_EN enables mask-copy verification
module task_dispatch_ctrl
    import task_dispatch_pkg::*;
#(
    parameter int DATA_DEPTH  = 1024,
    parameter int ADDR_W      = 10,
    parameter int INSTR_SIZE  = 16,
    parameter int CORE_NUM    = 16,
    parameter int FRAME_WORDS = task_dispatch_pkg::FRAME_WORDS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  prog_loading,
    input  logic [CORE_NUM-1:0]   core_ready,
    output logic                  mem_rd_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [INSTR_SIZE-1:0] mem_rdata,
    output logic                  dispatch_valid,
    input  logic                  dispatch_ready,
    output logic [CORE_NUM-1:0]   dispatch_mask,
    output logic [ADDR_W-1:0]     dispatch_base,
    output logic [6:0]            dispatch_frames,
    output logic [CORE_NUM-1:0]   reserved_mask,
    output logic                  prog_done,
    output logic                  prog_error
);

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     ptr_q, ptr_d;
    logic [INSTR_SIZE-1:0] hdr_q, hdr_d;
    logic [CORE_NUM-1:0]   mask_q, mask_d;

    logic [CORE_NUM-1:0]   free_mask;
    logic [N_W:0]          n_plus1;
    logic [ADDR_W:0]       task_len;
    logic [ADDR_W:0]       ptr_sum;
    logic [ADDR_W-1:0]     next_ptr;
    logic                  wrap;
    logic                  barrier_ok;
    logic                  excl_ok;
    logic                  issue_ok;
    logic                  copy_bad;

    assign n_plus1  = {1'b0, hdr_q[N_LSB +: N_W]} + (N_W+1)'(1);
    assign task_len = (ADDR_W+1)'(n_plus1) * (ADDR_W+1)'(FRAME_WORDS);
    assign ptr_sum  = {1'b0, ptr_q} + task_len;
    assign next_ptr = ptr_sum[ADDR_W-1:0];
    // Reaching or passing the end of memory ends the program after this task.
    assign wrap     = ptr_sum >= (ADDR_W+1)'(DATA_DEPTH);

    assign barrier_ok = !hdr_q[BARRIER_BIT] || (reserved_mask == '0);
    assign excl_ok    = !hdr_q[EXCL_BIT] || ((&core_ready) && (reserved_mask == '0));
    assign issue_ok   = ((mask_q & ~free_mask) == '0) && barrier_ok && excl_ok;

`ifdef MASK_CHECK_EN
    assign copy_bad = mem_rdata[CORE_NUM-1:0] != mask_q;
`else
    assign copy_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            hdr_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hdr_q   <= hdr_d;
            mask_q  <= mask_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hdr_d   = hdr_q;
        mask_d  = mask_q;
        case (state_q)
            ST_IDLE: begin
                ptr_d   = '0;
                state_d = ST_RD_HDR;
            end
            ST_RD_HDR: state_d = ST_RD_M0;
            ST_RD_M0: begin
                hdr_d   = mem_rdata;
                state_d = ST_RD_M1;
            end
            ST_RD_M1: begin
                mask_d  = mem_rdata[CORE_NUM-1:0];
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (hdr_q == END_OF_PROG) begin
                    state_d = ST_DONE;
                end else if (hdr_illegal(hdr_q) || (mask_q == '0) || copy_bad) begin
                    state_d = ST_ERR;
                end else if (issue_ok) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (issue_ok) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (dispatch_ready) begin
                    ptr_d   = next_ptr;
                    state_d = wrap ? ST_DONE : ST_RD_HDR;
                end
            end
            ST_DONE:  state_d = ST_DONE;
            ST_ERR:   state_d = ST_ERR;
            default:  state_d = ST_IDLE;
        endcase
        // Host reloading the program overrides everything; reservations survive.
        if (prog_loading) begin
            state_d = ST_IDLE;
            ptr_d   = '0;
        end
    end

    always_comb begin
        mem_rd_en       = 1'b0;
        mem_addr        = '0;
        dispatch_valid  = 1'b0;
        dispatch_mask   = '0;
        dispatch_base   = '0;
        dispatch_frames = '0;
        prog_done       = 1'b0;
        prog_error      = 1'b0;
        case (state_q)
            ST_RD_HDR: begin
                mem_rd_en = 1'b1;
                mem_addr  = ptr_q;
            end
            ST_RD_M0: begin
                mem_rd_en = 1'b1;
                mem_addr  = ptr_q + ADDR_W'(1);
            end
            ST_RD_M1: begin
                mem_rd_en = 1'b1;
                mem_addr  = ptr_q + ADDR_W'(2);
            end
            ST_ISSUE: begin
                dispatch_valid  = 1'b1;
                dispatch_mask   = mask_q;
                dispatch_base   = ptr_q;
                dispatch_frames = n_plus1;
            end
            ST_DONE:  prog_done  = 1'b1;
            ST_ERR:   prog_error = 1'b1;
            default: ;
        endcase
    end

    core_resv_tracker #(
        .CORE_NUM (CORE_NUM)
    ) u_resv (
        .clk           (clk),
        .reset         (reset),
        .core_ready    (core_ready),
        .set_en        (dispatch_valid && dispatch_ready),
        .set_mask      (mask_q),
        .reserved_mask (reserved_mask),
        .free_mask     (free_mask)
    );

endmodule

// File: tb/tb_task_dispatch_ctrl.sv
// tb/tb_task_dispatch_ctrl.sv - directed self-checking bench for task_dispatch_ctrl
module tb_task_dispatch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        prog_loading = 1'b1;
    logic [15:0] core_ready = 16'hFFFF;
    logic        mem_rd_en;
    logic [9:0]  mem_addr;
    logic [15:0] mem_rdata;
    logic        dispatch_valid;
    logic        dispatch_ready = 1'b1;
    logic [15:0] dispatch_mask;
    logic [9:0]  dispatch_base;
    logic [6:0]  dispatch_frames;
    logic [15:0] reserved_mask;
    logic        prog_done;
    logic        prog_error;

    logic [15:0] mem [0:1023];
    logic [15:0] resv_base;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task_dispatch_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .prog_loading    (prog_loading),
        .core_ready      (core_ready),
        .mem_rd_en       (mem_rd_en),
        .mem_addr        (mem_addr),
        .mem_rdata       (mem_rdata),
        .dispatch_valid  (dispatch_valid),
        .dispatch_ready  (dispatch_ready),
        .dispatch_mask   (dispatch_mask),
        .dispatch_base   (dispatch_base),
        .dispatch_frames (dispatch_frames),
        .reserved_mask   (reserved_mask),
        .prog_done       (prog_done),
        .prog_error      (prog_error)
    );

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    endtask

    task automatic put_task(input int addr, input logic [15:0] hdr, input logic [15:0] m, input logic [15:0] c);
        mem[addr]     = hdr;
        mem[addr + 1] = m;
        mem[addr + 2] = c;
    endtask

    task automatic wait_valid(input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (dispatch_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic watch_idle(input int n, output bit saw);
        saw = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (dispatch_valid) saw = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        prog_loading = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_rd_en !== 1'b0 || mem_addr !== 10'd0 || dispatch_valid !== 1'b0 || dispatch_mask !== 16'h0
            || dispatch_frames !== 7'd0 || reserved_mask !== 16'h0 || prog_done !== 1'b0 || prog_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got rd=%b addr=%h v=%b mask=%h fr=%0d resv=%h done=%b err=%b want all zero",
                     mem_rd_en, mem_addr, dispatch_valid, dispatch_mask, dispatch_frames, reserved_mask, prog_done, prog_error);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_first_task();
        bit found;
        int cnt;
        prog_loading = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_rd_en && mem_addr == 10'd0) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL first_hdr_read got none want read of addr 0");
        end
        cnt = 0;
        while (!dispatch_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (cnt != 4) begin
            errors++;
            $display("FAIL hdr_to_valid_latency got %0d want 4", cnt);
        end
        checks++;
        if (dispatch_mask !== 16'h000F || dispatch_frames !== 7'd4 || dispatch_base !== 10'd0) begin
            errors++;
            $display("FAIL task0_issue got mask=%h fr=%0d base=%0d want 000f 4 0", dispatch_mask, dispatch_frames, dispatch_base);
        end
        @(negedge clk);
        checks++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 10'd64 || reserved_mask !== 16'h000F) begin
            errors++;
            $display("FAIL task0_next got rd=%b addr=%0d resv=%h want 1 64 000f", mem_rd_en, mem_addr, reserved_mask);
        end
    endtask

    task automatic test_reserved_reuse();
        bit seen, saw;
        wait_valid(10, seen);
        checks++;
        if (!seen || dispatch_base !== 10'd64 || dispatch_mask !== 16'h00F0) begin
            errors++;
            $display("FAIL task64_issue got seen=%b base=%0d mask=%h want 1 64 00f0", seen, dispatch_base, dispatch_mask);
        end
        @(negedge clk);
        watch_idle(12, saw);
        checks++;
        if (saw || reserved_mask !== 16'h00FF) begin
            errors++;
            $display("FAIL task128_hold got valid=%b resv=%h want 0 00ff", saw, reserved_mask);
        end
        core_ready = 16'hFF0F;
        watch_idle(3, saw);
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL task128_low_hold got valid=1 want 0");
        end
        core_ready = 16'hFFFF;
        wait_valid(10, seen);
        checks++;
        if (!seen || dispatch_base !== 10'd128 || dispatch_mask !== 16'h00F0) begin
            errors++;
            $display("FAIL task128_issue got seen=%b base=%0d mask=%h want 1 128 00f0", seen, dispatch_base, dispatch_mask);
        end
        @(negedge clk);
        checks++;
        if (reserved_mask !== 16'h00FF) begin
            errors++;
            $display("FAIL task128_resv got %h want 00ff", reserved_mask);
        end
    endtask

    task automatic test_barrier();
        bit seen, saw;
        watch_idle(12, saw);
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL barrier_hold got valid=1 want 0");
        end
        core_ready = 16'hFF0F;
        @(negedge clk);
        core_ready = 16'hFFFF;
        watch_idle(4, saw);
        checks++;
        if (saw || reserved_mask !== 16'h000F) begin
            errors++;
            $display("FAIL barrier_partial got valid=%b resv=%h want 0 000f", saw, reserved_mask);
        end
        core_ready = 16'hFFF0;
        @(negedge clk);
        core_ready = 16'hFFFF;
        wait_valid(10, seen);
        checks++;
        if (!seen || dispatch_base !== 10'd192 || dispatch_mask !== 16'h0100 || dispatch_frames !== 7'd4) begin
            errors++;
            $display("FAIL barrier_issue got seen=%b base=%0d mask=%h fr=%0d want 1 192 0100 4",
                     seen, dispatch_base, dispatch_mask, dispatch_frames);
        end
        @(negedge clk);
    endtask

    task automatic test_exclusive();
        bit seen, saw;
        core_ready = 16'hFE0F;
        watch_idle(12, saw);
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL excl_hold got valid=1 want 0");
        end
        core_ready = 16'hFF0F;
        watch_idle(4, saw);
        checks++;
        if (saw || reserved_mask !== 16'h0000) begin
            errors++;
            $display("FAIL excl_not_all_ready got valid=%b resv=%h want 0 0000", saw, reserved_mask);
        end
        core_ready = 16'hFFFF;
        wait_valid(10, seen);
        checks++;
        if (!seen || dispatch_base !== 10'd256 || dispatch_mask !== 16'h0F00 || dispatch_frames !== 7'd16) begin
            errors++;
            $display("FAIL excl_issue got seen=%b base=%0d mask=%h fr=%0d want 1 256 0f00 16",
                     seen, dispatch_base, dispatch_mask, dispatch_frames);
        end
        @(negedge clk);
        checks++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 10'd512) begin
            errors++;
            $display("FAIL excl_next_ptr got rd=%b addr=%0d want 1 512", mem_rd_en, mem_addr);
        end
    endtask

    task automatic test_done();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (prog_done) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done || dispatch_valid !== 1'b0 || prog_error !== 1'b0) begin
            errors++;
            $display("FAIL end_of_program got done=%b v=%b err=%b want 1 0 0", done, dispatch_valid, prog_error);
        end
    endtask

    task automatic test_errors();
        bit saw, err;
        logic [15:0] m;
        prog_loading = 1'b1;
        @(negedge clk);
        checks++;
        if (prog_done !== 1'b0) begin
            errors++;
            $display("FAIL done_clear got %b want 0", prog_done);
        end
        clear_mem();
        put_task(0, 16'h0003, 16'h000F, 16'h00F0);
        put_task(64, 16'h0103, 16'h0001, 16'h0001);
        prog_loading = 1'b0;
        saw = 1'b0;
        err = 1'b0;
        m = 16'h0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (dispatch_valid) begin
                saw = 1'b1;
                m = dispatch_mask;
            end
            if (prog_error) err = 1'b1;
        end
        checks++;
        if (!err || prog_error !== 1'b1 || prog_done !== 1'b0) begin
            errors++;
            $display("FAIL bad_desc_error got seen=%b err=%b done=%b want 1 1 0", err, prog_error, prog_done);
        end
`ifdef MASK_CHECK_EN
        checks++;
        if (saw) begin
            errors++;
            $display("FAIL copy_mismatch_dispatch got valid=1 mask=%h want no dispatch", m);
        end
`else
        checks++;
        if (!saw || m !== 16'h000F) begin
            errors++;
            $display("FAIL copy_ignored_dispatch got seen=%b mask=%h want 1 000f", saw, m);
        end
`endif
        prog_loading = 1'b1;
        @(negedge clk);
        checks++;
        if (prog_error !== 1'b0) begin
            errors++;
            $display("FAIL error_clear got %b want 0", prog_error);
        end
        clear_mem();
        put_task(0, 16'h0001, 16'h0000, 16'h0000);
        prog_loading = 1'b0;
        saw = 1'b0;
        err = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dispatch_valid) saw = 1'b1;
            if (prog_error) err = 1'b1;
        end
        checks++;
        if (!err || saw) begin
            errors++;
            $display("FAIL zero_mask_error got err=%b valid=%b want 1 0", err, saw);
        end
    endtask

    task automatic test_abort();
        bit seen;
`ifdef MASK_CHECK_EN
        resv_base = 16'h0F00;
`else
        resv_base = 16'h0F0F;
`endif
        prog_loading = 1'b1;
        @(negedge clk);
        clear_mem();
        put_task(0, 16'h0003, 16'h1000, 16'h1000);
        dispatch_ready = 1'b0;
        prog_loading = 1'b0;
        @(negedge clk);
        wait_valid(12, seen);
        checks++;
        if (!seen || dispatch_mask !== 16'h1000 || reserved_mask !== resv_base) begin
            errors++;
            $display("FAIL abort_setup got seen=%b mask=%h resv=%h want 1 1000 %h", seen, dispatch_mask, reserved_mask, resv_base);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (dispatch_valid !== 1'b1 || dispatch_mask !== 16'h1000 || dispatch_base !== 10'd0 || dispatch_frames !== 7'd4) begin
            errors++;
            $display("FAIL issue_stable got v=%b mask=%h base=%0d fr=%0d want 1 1000 0 4",
                     dispatch_valid, dispatch_mask, dispatch_base, dispatch_frames);
        end
        prog_loading = 1'b1;
        @(negedge clk);
        checks++;
        if (dispatch_valid !== 1'b0 || reserved_mask !== resv_base || mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL abort_drop got v=%b resv=%h rd=%b want 0 %h 0", dispatch_valid, reserved_mask, mem_rd_en, resv_base);
        end
        prog_loading = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 10'd0) begin
            errors++;
            $display("FAIL abort_refetch got rd=%b addr=%0d want 1 0", mem_rd_en, mem_addr);
        end
        dispatch_ready = 1'b1;
        wait_valid(12, seen);
        @(negedge clk);
        checks++;
        if (!seen || reserved_mask !== (resv_base | 16'h1000)) begin
            errors++;
            $display("FAIL refetch_issue got seen=%b resv=%h want 1 %h", seen, reserved_mask, resv_base | 16'h1000);
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b0;
        prog_loading = 1'b1;
        @(negedge clk);
        checks++;
        if (reserved_mask !== 16'h0000 || prog_done !== 1'b0 || dispatch_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got resv=%h done=%b v=%b want 0000 0 0", reserved_mask, prog_done, dispatch_valid);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        clear_mem();
        put_task(0,   16'h0003, 16'h000F, 16'h000F);
        put_task(64,  16'h0003, 16'h00F0, 16'h00F0);
        put_task(128, 16'h0003, 16'h00F0, 16'h00F0);
        put_task(192, 16'h0043, 16'h0100, 16'h0100);
        put_task(256, 16'h008F, 16'h0F00, 16'h0F00);
        @(negedge clk);
        test_reset();
        test_first_task();
        test_reserved_reuse();
        test_barrier();
        test_exclusive();
        test_done();
        test_errors();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
